// File: rtl/simplez_pkg.sv
// rtl/simplez_pkg.sv - shared Simplez bus widths, opcodes, peripheral map and status bits
//
// Contents:
//   DATAW, ADDRW          data and address bus widths
//   OP_*                  3-bit instruction opcodes
//   ADDR_*                peripheral address map (LED port, UART data, UART status)
//   STAT_*                bit positions within the UART status word
package simplez_pkg;

  localparam int DATAW = 12;
  localparam int ADDRW = 9;

  localparam logic [2:0] OP_ST   = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_BZ   = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [ADDRW-1:0] ADDR_LEDS      = 9'o100;
  localparam logic [ADDRW-1:0] ADDR_UART_DATA = 9'o101;
  localparam logic [ADDRW-1:0] ADDR_UART_STAT = 9'o102;

  // Status word: bit0 = holding register empty, bit1 = overrun, bit2 = busy
  localparam int STAT_TXE  = 0;
  localparam int STAT_OVR  = 1;
  localparam int STAT_BUSY = 2;

endpackage

// File: rtl/simplez_baud_tick.sv
// rtl/simplez_baud_tick.sv - free-running baud down-counter emitting one tick per bit period
//
// Ports:
//   clk   in   system clock, state updates on the falling edge
//   rstn  in   synchronous active-low reset
//   en    in   count enable; while low the counter is held at 0
//   tick  out  high whenever the counter is 0 (end of a bit period)
module simplez_baud_tick #(
  parameter int BAUD_DIV = 104
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  // tick depends only on the count, so the enable may itself be a
  // function of tick without forming a combinational loop.
  assign tick = (cnt == '0);

  always_ff @(negedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/simplez_uart_tx.sv
// rtl/simplez_uart_tx.sv - memory-mapped 8N1 serial transmitter with one-entry holding register
//
// Ports:
//   clk       in   system clock, state updates on the falling edge
//   rstn      in   synchronous active-low reset
//   addr      in   CPU external address register value
//   wr        in   CPU write strobe
//   data_in   in   CPU data bus during a write
//   data_out  out  combinational read data (status word, holding register or 0)
//   cs        out  high when addr selects the data or status register
//   tx        out  registered serial line, idle high
//   busy      out  high while a frame is being shifted out
module simplez_uart_tx #(
  parameter int                          DATAW     = simplez_pkg::DATAW,
  parameter int                          ADDRW     = simplez_pkg::ADDRW,
  parameter int                          BAUD_DIV  = 104,
  parameter logic [simplez_pkg::ADDRW-1:0] ADDR_DATA = simplez_pkg::ADDR_UART_DATA,
  parameter logic [simplez_pkg::ADDRW-1:0] ADDR_STAT = simplez_pkg::ADDR_UART_STAT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [ADDRW-1:0] addr,
  input  logic             wr,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             cs,
  output logic             tx,
  output logic             busy
);

  import simplez_pkg::*;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0] state;
  logic [7:0] hold;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic       hold_full;
  logic       overrun;
  logic       tick;
  logic       baud_en;
  logic       sel_data;
  logic       sel_stat;
  logic       wr_data;
  logic       wr_stat;
  logic       stop_done;
  logic       xfer;
  logic       unused_bits;

  assign sel_data = (addr == ADDR_DATA);
  assign sel_stat = (addr == ADDR_STAT);
  assign cs       = sel_data | sel_stat;
  assign wr_data  = wr & sel_data;
  assign wr_stat  = wr & sel_stat;

  // Only the low byte is transmitted.
  assign unused_bits = ^data_in[DATAW-1:8];

  assign busy      = (state != S_IDLE);
  assign stop_done = (state == S_STOP) & tick;

  // Hold moves into the shifter either from idle or straight at the end of
  // a stop bit, which is what gives back-to-back frames no idle gap.
  assign xfer = hold_full & ((state == S_IDLE) | stop_done);

  // Counter runs from the edge a frame is launched until the stop bit that
  // returns to idle; dropping enable on that edge leaves it at 0 so the
  // next launch always starts a full bit period.
  always_comb begin
    baud_en = 1'b0;
    if (state == S_IDLE) begin
      baud_en = hold_full;
    end else begin
      baud_en = !(stop_done && !hold_full);
    end
  end

  simplez_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk (clk),
    .rstn(rstn),
    .en  (baud_en),
    .tick(tick)
  );

  always_comb begin
    data_out = '0;
    if (sel_stat) begin
      data_out[STAT_TXE]  = ~hold_full;
      data_out[STAT_OVR]  = overrun;
      data_out[STAT_BUSY] = busy;
    end else if (sel_data) begin
      data_out[7:0] = hold;
    end
  end

  // Holding register and overrun flag
  always_ff @(negedge clk) begin
    if (!rstn) begin
      hold      <= '0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (wr_data && (!hold_full || xfer)) begin
        hold      <= data_in[7:0];
        hold_full <= 1'b1;
      end else if (xfer) begin
        hold_full <= 1'b0;
      end

      if (wr_data && hold_full && !xfer) begin
        overrun <= 1'b1;
      end else if (wr_stat) begin
        overrun <= 1'b0;
      end
    end
  end

  // Frame sequencer; tx is driven only from this register
  always_ff @(negedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      shift   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (xfer) begin
            shift <= hold;
            tx    <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (xfer) begin
              shift <= hold;
              tx    <= 1'b0;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
